// File: rtl/erasable_array.sv
// Erasable core word array with X/Y coincident select, destructive sense and write-back.
// Optional odd-parity check on sensed words enabled by defining ERASABLE_PARITY_CHK_EN.
module erasable_array #(
  parameter int unsigned WORDS = 2048
) (
  input  logic        CLOCK,
  input  logic        rst,
  input  logic [7:0]  XTE,
  input  logic [7:0]  XBE,
  input  logic [7:0]  YTE,
  input  logic [3:0]  YBE,
  input  logic        REX,
  input  logic        REY,
  input  logic        SBE,
  input  logic        WEX,
  input  logic        WEY,
  input  logic        ZID,
  input  logic [15:0] WD,
  output logic [15:0] SA,
  output logic        SAV,
  output logic        BUSY,
  output logic        SELERR,
  output logic        PARERR
);

  localparam int unsigned AW = 11;

  typedef enum logic [1:0] {IDLE, SELECTED, SENSED, WRITE} state_t;

  state_t          state;
  logic [AW-1:0]   addr;
  logic [15:0]     mem [WORDS];

  logic            rd_req;
  logic            wr_req;
  logic            sel_ok;
  logic [AW-1:0]   sel_addr;
  logic            mem_we;
  logic [15:0]     mem_wdata;
  logic [15:0]     rd_word;
  logic            par_fail;

  function automatic logic [2:0] idx8(input logic [7:0] v);
    logic [2:0] r;
    r = '0;
    for (int unsigned i = 0; i < 8; i++)
      if (v[i]) r = i[2:0];
    return r;
  endfunction

  function automatic logic [1:0] idx4(input logic [3:0] v);
    logic [1:0] r;
    r = '0;
    for (int unsigned i = 0; i < 4; i++)
      if (v[i]) r = i[1:0];
    return r;
  endfunction

  always_comb begin
    rd_req   = REX & REY;
    wr_req   = WEX & WEY;
    sel_ok   = $onehot(XTE) & $onehot(XBE) & $onehot(YTE) & $onehot(YBE);
    sel_addr = {idx4(YBE), idx8(YTE), idx8(XBE), idx8(XTE)};
    rd_word  = mem[addr];
  end

  // Single array write port: sensing clears the word, write-back restores it.
  always_comb begin
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (state == SELECTED && SBE) begin
      mem_we    = 1'b1;
      mem_wdata = '0;
    end else if (state == SENSED && wr_req) begin
      mem_we    = 1'b1;
      mem_wdata = ZID ? '0 : WD;
    end
  end

`ifdef ERASABLE_PARITY_CHK_EN
  // Stored words carry odd parity; an all-zero word is a legitimately cleared location.
  always_comb par_fail = (rd_word != '0) && !(^rd_word);
`else
  always_comb par_fail = 1'b0;
`endif

  // Core contents are non-volatile and deliberately outside the reset domain.
  always_ff @(posedge CLOCK) begin
    if (mem_we) mem[addr] <= mem_wdata;
  end

  always_ff @(posedge CLOCK or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      addr   <= '0;
      SA     <= '0;
      SAV    <= 1'b0;
      BUSY   <= 1'b0;
      SELERR <= 1'b0;
      PARERR <= 1'b0;
    end else begin
      SAV    <= 1'b0;
      SELERR <= 1'b0;
      PARERR <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_req) SELERR <= 1'b1;
          if (rd_req) begin
            if (sel_ok) begin
              state <= SELECTED;
              addr  <= sel_addr;
              BUSY  <= 1'b1;
            end else begin
              SELERR <= 1'b1;
            end
          end
        end
        SELECTED: begin
          if (wr_req) SELERR <= 1'b1;
          if (SBE) begin
            state  <= SENSED;
            SA     <= rd_word;
            SAV    <= 1'b1;
            PARERR <= par_fail;
          end
        end
        SENSED: begin
          if (wr_req) state <= WRITE;
        end
        WRITE: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_erasable_array.sv
// Scoreboard bench for erasable_array: stimulus pushes expected sensed words,
// a negedge monitor pops and compares them whenever SAV is presented.
module tb_erasable_array;

  logic        CLOCK;
  logic        rst;
  logic [7:0]  XTE, XBE, YTE;
  logic [3:0]  YBE;
  logic        REX, REY, SBE, WEX, WEY, ZID;
  logic [15:0] WD;
  logic [15:0] SA;
  logic        SAV, BUSY, SELERR, PARERR;

  erasable_array #(.WORDS(2048)) dut (
    .CLOCK(CLOCK), .rst(rst),
    .XTE(XTE), .XBE(XBE), .YTE(YTE), .YBE(YBE),
    .REX(REX), .REY(REY), .SBE(SBE), .WEX(WEX), .WEY(WEY),
    .ZID(ZID), .WD(WD),
    .SA(SA), .SAV(SAV), .BUSY(BUSY), .SELERR(SELERR), .PARERR(PARERR)
  );

  typedef struct {
    logic [15:0] sa;
    logic        par;
    logic        dc;
  } exp_t;

  exp_t q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  initial begin
    CLOCK = 1'b0;
    forever #5 CLOCK = ~CLOCK;
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic set_addr(input logic [10:0] a);
    XTE = 8'h01 << a[2:0];
    XBE = 8'h01 << a[5:3];
    YTE = 8'h01 << a[8:6];
    YBE = 4'h1  << a[10:9];
  endtask

  task automatic push(input logic [15:0] sa, input logic par, input logic dc);
    exp_t e;
    e.sa = sa;
`ifdef ERASABLE_PARITY_CHK_EN
    e.par = par;
`else
    e.par = 1'b0;
`endif
    e.dc = dc;
    q.push_back(e);
  endtask

  // Full select / sense / write-back cycle; dc marks a word of unknown prior content.
  task automatic access(input logic [10:0] a, input logic [15:0] wd, input logic zid,
                        input logic dc, input logic [15:0] exp_sa, input logic exp_par);
    set_addr(a);
    REX = 1'b1; REY = 1'b1;
    tick();
    REX = 1'b0; REY = 1'b0;
    chk("busy_selected", {15'd0, BUSY}, 16'd1);
    push(exp_sa, exp_par, dc);
    SBE = 1'b1;
    tick();
    SBE = 1'b0;
    chk("busy_sensed", {15'd0, BUSY}, 16'd1);
    WEX = 1'b1; WEY = 1'b1; WD = wd; ZID = zid;
    tick();
    WEX = 1'b0; WEY = 1'b0; ZID = 1'b0;
    chk("busy_write", {15'd0, BUSY}, 16'd1);
    tick();
    chk("busy_idle", {15'd0, BUSY}, 16'd0);
  endtask

  always @(negedge CLOCK) begin
    if (rst && SAV) begin
      if (q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_sav: got SAV=1 SA=%h expected no SAV", SA);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (!e.dc) begin
          chk("sa", SA, e.sa);
          chk("parerr", {15'd0, PARERR}, {15'd0, e.par});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    XTE = '0; XBE = '0; YTE = '0; YBE = '0;
    REX = 1'b0; REY = 1'b0; SBE = 1'b0; WEX = 1'b0; WEY = 1'b0; ZID = 1'b0; WD = '0;
    #2 rst = 1'b0;
    #1;
    chk("rst_sa", SA, 16'h0000);
    chk("rst_sav", {15'd0, SAV}, 16'd0);
    chk("rst_busy", {15'd0, BUSY}, 16'd0);
    chk("rst_selerr", {15'd0, SELERR}, 16'd0);
    chk("rst_parerr", {15'd0, PARERR}, 16'd0);
    tick();
    tick();
    @(negedge CLOCK);
    rst = 1'b1;
    tick();

    // Word 0x000: preload, sense/restore, then parity vectors
    access(11'h000, 16'h8001, 1'b0, 1'b1, 16'h0000, 1'b0);
    access(11'h000, 16'h8001, 1'b0, 1'b0, 16'h8001, 1'b1);
    access(11'h000, 16'h0003, 1'b0, 1'b0, 16'h8001, 1'b1);
    access(11'h000, 16'h0001, 1'b0, 1'b0, 16'h0003, 1'b1);
    access(11'h000, 16'h0001, 1'b0, 1'b0, 16'h0001, 1'b0);

    // Word 0x7FF: zero-inhibit write-back
    access(11'h7FF, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b0);
    access(11'h7FF, 16'h5555, 1'b1, 1'b0, 16'h1234, 1'b0);
    access(11'h7FF, 16'h4321, 1'b0, 1'b0, 16'h0000, 1'b0);
    access(11'h7FF, 16'h4321, 1'b0, 1'b0, 16'h4321, 1'b0);

    // Distinct field values must not alias word 0x000
    access(11'h5AC, 16'h0F0F, 1'b0, 1'b1, 16'h0000, 1'b0);
    access(11'h000, 16'h0001, 1'b0, 1'b0, 16'h0001, 1'b0);
    access(11'h5AC, 16'h0F0F, 1'b0, 1'b0, 16'h0F0F, 1'b1);

    // Multi-hot and zero select
    set_addr(11'h000);
    XTE = 8'h03;
    REX = 1'b1; REY = 1'b1;
    tick();
    REX = 1'b0; REY = 1'b0;
    chk("multihot_selerr", {15'd0, SELERR}, 16'd1);
    chk("multihot_busy", {15'd0, BUSY}, 16'd0);
    tick();
    chk("selerr_width", {15'd0, SELERR}, 16'd0);
    set_addr(11'h000);
    YBE = 4'h0;
    REX = 1'b1; REY = 1'b1;
    tick();
    REX = 1'b0; REY = 1'b0;
    chk("zero_sel_selerr", {15'd0, SELERR}, 16'd1);
    chk("zero_sel_busy", {15'd0, BUSY}, 16'd0);

    // Write strobe in IDLE, and sense strobe in IDLE (no SAV expected)
    set_addr(11'h000);
    WEX = 1'b1; WEY = 1'b1; WD = 16'hFFFF;
    tick();
    WEX = 1'b0; WEY = 1'b0;
    chk("idle_write_selerr", {15'd0, SELERR}, 16'd1);
    chk("idle_write_busy", {15'd0, BUSY}, 16'd0);
    SBE = 1'b1;
    tick();
    SBE = 1'b0;
    chk("idle_sbe_busy", {15'd0, BUSY}, 16'd0);
    tick();
    access(11'h000, 16'h0001, 1'b0, 1'b0, 16'h0001, 1'b0);

    // Reset while SENSED, with select buses changed after latching
    access(11'h0AA, 16'h00F0, 1'b0, 1'b1, 16'h0000, 1'b0);
    set_addr(11'h0AA);
    REX = 1'b1; REY = 1'b1;
    tick();
    REX = 1'b0; REY = 1'b0;
    XTE = 8'h80; YBE = 4'h8;
    push(16'h00F0, 1'b1, 1'b0);
    SBE = 1'b1;
    tick();
    SBE = 1'b0;
    @(negedge CLOCK);
    #1 rst = 1'b0;
    #1;
    chk("async_rst_sa", SA, 16'h0000);
    chk("async_rst_sav", {15'd0, SAV}, 16'd0);
    chk("async_rst_busy", {15'd0, BUSY}, 16'd0);
    chk("async_rst_parerr", {15'd0, PARERR}, 16'd0);
    #1 rst = 1'b1;
    tick();
    chk("post_rst_busy", {15'd0, BUSY}, 16'd0);
    access(11'h0AA, 16'h1111, 1'b0, 1'b0, 16'h0000, 1'b0);

    tick();
    tick();
    n_total++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL missing_sav: got %0d pending expected 0", q.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/erasable_array.md
ERASABLE_ARRAY -- requirements
Module: erasable_array

Interface
REQ-001 Parameter WORDS, default 2048, meaning: array depth; fixed by the 8 XT x 8 XB x 8 YT x 4 YB select space.
REQ-002 CLOCK  input  1  single system clock; all state changes on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 XTE  input  8  one-hot X-top select enable (XT0E..XT7E order, bit0 = XT0E).
REQ-005 XBE  input  8  one-hot X-bottom select enable (bit0 = XB0E).
REQ-006 YTE  input  8  one-hot Y-top select enable (bit0 = YT0E).
REQ-007 YBE  input  4  one-hot Y-bottom select enable (bit0 = YB0E).
REQ-008 REX, REY  input  1 each  read-current strobes; coincident high = read select.
REQ-009 SBE  input  1  erasable sense strobe.
REQ-010 WEX, WEY  input  1 each  write-current strobes; coincident high = write.
REQ-011 ZID  input  1  zero-inhibit-drive: when high, write-back stores all zeros.
REQ-012 WD  input  16  write-back data (bit15 = parity, bits14:0 = data).
REQ-013 SA  output  16  sensed word.
REQ-014 SAV  output  1  one-cycle pulse: SA valid.
REQ-015 BUSY  output  1  high in any state other than IDLE.
REQ-016 SELERR  output  1  one-cycle pulse: illegal select or out-of-order strobe.
REQ-017 PARERR  output  1  one-cycle pulse coincident with SAV on odd-parity failure (see Configuration).

Function
REQ-018 Address = {YB index, YT index, XB index, XT index} = 11 bits, index = position of the single set bit in each select bus.
REQ-019 States: IDLE, SELECTED, SENSED, WRITE; transitions evaluated once per rising edge.
REQ-020 IDLE -> SELECTED when REX & REY high and all four select buses exactly one-hot; address latched same edge.
REQ-021 IDLE with REX & REY high and any select bus zero or multi-hot: stay IDLE, pulse SELERR, no array access.
REQ-022 SELECTED -> SENSED on first edge with SBE high; SA <= array[addr], array[addr] <= 0 (destructive read), SAV pulses next cycle.
REQ-023 SENSED -> WRITE on first edge with WEX & WEY high; array[addr] <= ZID ? 0 : WD on that edge.
REQ-024 WRITE -> IDLE on next edge unconditionally; BUSY drops same edge.
REQ-025 WEX & WEY high in IDLE or SELECTED: no write, pulse SELERR, state unchanged.
REQ-026 SBE high in IDLE, SENSED or WRITE: ignored, no SAV.
REQ-027 Select buses may change after latching in SELECTED/SENSED without affecting the latched address.
REQ-028 REX & REY and WEX & WEY simultaneously high in IDLE: read select wins, SELERR pulses for the write.
REQ-029 SA holds its value until the next sense; SAV is exactly one cycle wide.

Reset
REQ-030 rst low: state IDLE, SA = 0, SAV = 0, BUSY = 0, SELERR = 0, PARERR = 0, latched address = 0, immediately and asynchronously.
REQ-031 Array contents are NOT cleared by rst (core is non-volatile); a word destructively read before reset remains zero.
REQ-032 Deassertion of rst takes effect on the following rising edge of CLOCK.

Configuration
REQ-033 Macro ERASABLE_PARITY_CHK_EN defined: PARERR pulses with SAV when the sensed 16-bit word has even parity, except an all-zero word is exempt.
REQ-034 Macro ERASABLE_PARITY_CHK_EN undefined: PARERR tied to 0; no parity logic instantiated.

Verification
REQ-035 Preload array[0x000]=16'h8001; XTE=XBE=YTE=8'h01, YBE=4'h1, REX=REY=1, SBE, then WEX=WEY=1, WD=16'h8001 -> SA=16'h8001, SAV one cycle, word restored, BUSY high 3 cycles.
REQ-036 Read address 0x7FF (all selects top bit), SBE, then write with ZID=1 -> SA = prior value, subsequent read returns 16'h0000.
REQ-037 REX=REY=1 with XTE=8'h03 -> SELERR one cycle, state IDLE, BUSY=0, array unchanged.
REQ-038 WEX=WEY=1 while IDLE -> SELERR one cycle, no array write.
REQ-039 rst low while in SENSED -> all outputs 0 asynchronously, state IDLE, sensed word reads back 16'h0000.
REQ-040 With ERASABLE_PARITY_CHK_EN, sense word 16'h0003 -> PARERR=1 with SAV; sense 16'h0001 -> PARERR=0; without macro PARERR=0 for both.
